// File: rtl/wb_backdoor_arbiter.sv
// Two-master to three-slave Wishbone arbiter with round-robin tie-break,
// registered slave-side request, per-transfer timeout and abort on cyc drop.
module wb_backdoor_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] m0_wb_data_i,
  input  logic [31:0] m0_wb_addr_i,
  input  logic        m0_wb_cyc_i,
  input  logic        m0_wb_strobe_i,
  input  logic        m0_wb_we_i,
  output logic [31:0] m0_wb_data_o,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_err_o,
  input  logic [31:0] m1_wb_data_i,
  input  logic [31:0] m1_wb_addr_i,
  input  logic        m1_wb_cyc_i,
  input  logic        m1_wb_strobe_i,
  input  logic        m1_wb_we_i,
  output logic [31:0] m1_wb_data_o,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_err_o,
  output logic [31:0] s_wb_data_o,
  output logic [31:0] s_wb_addr_o,
  output logic        s_wb_we_o,
  output logic        s_wb_cyc_o,
  output logic [2:0]  s_wb_strobe_o,
  input  logic [31:0] s_wb_data_i_0,
  input  logic [31:0] s_wb_data_i_1,
  input  logic [31:0] s_wb_data_i_2,
  input  logic [2:0]  s_wb_ack_i,
  output logic        busy_o,
  output logic        owner_o
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic        errFlag_q, errFlag_d;
  logic [7:0]  timer_q, timer_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        cyc_q, cyc_d;
  logic [2:0]  strobe_q, strobe_d;
  logic [31:0] m0Data_q, m0Data_d;
  logic [31:0] m1Data_q, m1Data_d;

  logic        req0, req1, winner, ownerCyc, selAck;
  logic [31:0] winAddr;
  logic [31:0] readData;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      errFlag_q <= 1'b0;
      timer_q   <= 8'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      strobe_q  <= 3'b000;
      m0Data_q  <= 32'd0;
      m1Data_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      errFlag_q <= errFlag_d;
      timer_q   <= timer_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      cyc_q     <= cyc_d;
      strobe_q  <= strobe_d;
      m0Data_q  <= m0Data_d;
      m1Data_q  <= m1Data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    errFlag_d = errFlag_q;
    timer_d   = timer_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    strobe_d  = strobe_q;
    m0Data_d  = m0Data_q;
    m1Data_d  = m1Data_q;

    req0     = m0_wb_cyc_i & m0_wb_strobe_i;
    req1     = m1_wb_cyc_i & m1_wb_strobe_i;
    // On a tie the master that was not granted last wins.
    winner   = (req0 && req1) ? ~last_q : req1;
    winAddr  = winner ? m1_wb_addr_i : m0_wb_addr_i;
    ownerCyc = owner_q ? m1_wb_cyc_i : m0_wb_cyc_i;
    selAck   = |(s_wb_ack_i & strobe_q);

    readData = 32'd0;
    if (strobe_q[0]) readData = s_wb_data_i_0;
    if (strobe_q[1]) readData = s_wb_data_i_1;
    if (strobe_q[2]) readData = s_wb_data_i_2;

    case (state_q)
      IDLE: begin
        errFlag_d = 1'b0;
        if (req0 || req1) begin
          owner_d = winner;
          last_d  = winner;
          addr_d  = winAddr;
          wdata_d = winner ? m1_wb_data_i : m0_wb_data_i;
          we_d    = winner ? m1_wb_we_i : m0_wb_we_i;
          timer_d = 8'd0;
          if (winAddr[17:16] == 2'd3) begin
            state_d   = DONE;
            errFlag_d = 1'b1;
            cyc_d     = 1'b0;
            strobe_d  = 3'b000;
          end else begin
            state_d  = ACTIVE;
            cyc_d    = 1'b1;
            strobe_d = 3'b001 << winAddr[17:16];
          end
        end
      end
      ACTIVE: begin
        if (!ownerCyc) begin
          state_d  = IDLE;
          cyc_d    = 1'b0;
          strobe_d = 3'b000;
        end else if (selAck) begin
          state_d  = DONE;
          cyc_d    = 1'b0;
          strobe_d = 3'b000;
          if (!we_q) begin
            if (owner_q) m1Data_d = readData;
            else         m0Data_d = readData;
          end
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          state_d   = DONE;
          errFlag_d = 1'b1;
          cyc_d     = 1'b0;
          strobe_d  = 3'b000;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign m0_wb_ack_o   = (state_q == DONE) && !owner_q && !errFlag_q;
  assign m0_wb_err_o   = (state_q == DONE) && !owner_q &&  errFlag_q;
  assign m1_wb_ack_o   = (state_q == DONE) &&  owner_q && !errFlag_q;
  assign m1_wb_err_o   = (state_q == DONE) &&  owner_q &&  errFlag_q;
  assign m0_wb_data_o  = m0Data_q;
  assign m1_wb_data_o  = m1Data_q;
  assign s_wb_data_o   = wdata_q;
  assign s_wb_addr_o   = addr_q;
  assign s_wb_we_o     = we_q;
  assign s_wb_cyc_o    = cyc_q;
  assign s_wb_strobe_o = strobe_q;
  assign busy_o        = (state_q != IDLE);
  assign owner_o       = owner_q;

endmodule

// File: tb/tb_wb_backdoor_arbiter.sv
// Directed bench for wb_backdoor_arbiter: reads, writes, tie-break, unmapped
// address, timeout, reset and abort, each checked against hand-computed values.
module tb_wb_backdoor_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] m0_wb_data_i, m0_wb_addr_i, m1_wb_data_i, m1_wb_addr_i;
  logic        m0_wb_cyc_i, m0_wb_strobe_i, m0_wb_we_i;
  logic        m1_wb_cyc_i, m1_wb_strobe_i, m1_wb_we_i;
  logic [31:0] m0_wb_data_o, m1_wb_data_o;
  logic        m0_wb_ack_o, m0_wb_err_o, m1_wb_ack_o, m1_wb_err_o;
  logic [31:0] s_wb_data_o, s_wb_addr_o;
  logic        s_wb_we_o, s_wb_cyc_o;
  logic [2:0]  s_wb_strobe_o;
  logic [31:0] s_wb_data_i_0, s_wb_data_i_1, s_wb_data_i_2;
  logic [2:0]  s_wb_ack_i;
  logic        busy_o, owner_o;

  int total  = 0;
  int passed = 0;

  wb_backdoor_arbiter #(.TIMEOUT(15)) dut (
    .clock(clock), .reset(reset),
    .m0_wb_data_i(m0_wb_data_i), .m0_wb_addr_i(m0_wb_addr_i),
    .m0_wb_cyc_i(m0_wb_cyc_i), .m0_wb_strobe_i(m0_wb_strobe_i), .m0_wb_we_i(m0_wb_we_i),
    .m0_wb_data_o(m0_wb_data_o), .m0_wb_ack_o(m0_wb_ack_o), .m0_wb_err_o(m0_wb_err_o),
    .m1_wb_data_i(m1_wb_data_i), .m1_wb_addr_i(m1_wb_addr_i),
    .m1_wb_cyc_i(m1_wb_cyc_i), .m1_wb_strobe_i(m1_wb_strobe_i), .m1_wb_we_i(m1_wb_we_i),
    .m1_wb_data_o(m1_wb_data_o), .m1_wb_ack_o(m1_wb_ack_o), .m1_wb_err_o(m1_wb_err_o),
    .s_wb_data_o(s_wb_data_o), .s_wb_addr_o(s_wb_addr_o),
    .s_wb_we_o(s_wb_we_o), .s_wb_cyc_o(s_wb_cyc_o), .s_wb_strobe_o(s_wb_strobe_o),
    .s_wb_data_i_0(s_wb_data_i_0), .s_wb_data_i_1(s_wb_data_i_1), .s_wb_data_i_2(s_wb_data_i_2),
    .s_wb_ack_i(s_wb_ack_i), .busy_o(busy_o), .owner_o(owner_o)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input int master, input logic cyc, input logic stb,
                               input logic we, input logic [31:0] addr, input logic [31:0] data);
    if (master == 0) begin
      m0_wb_cyc_i = cyc; m0_wb_strobe_i = stb; m0_wb_we_i = we;
      m0_wb_addr_i = addr; m0_wb_data_i = data;
    end else begin
      m1_wb_cyc_i = cyc; m1_wb_strobe_i = stb; m1_wb_we_i = we;
      m1_wb_addr_i = addr; m1_wb_data_i = data;
    end
  endtask

  // Packs the four completion outputs as {m1_err, m1_ack, m0_err, m0_ack}.
  function automatic logic [31:0] comp();
    return {28'd0, m1_wb_err_o, m1_wb_ack_o, m0_wb_err_o, m0_wb_ack_o};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 32'd0, 32'd0);
    applyStimulus(1, 0, 0, 0, 32'd0, 32'd0);
    s_wb_ack_i = 3'b000;
    s_wb_data_i_0 = 32'd0; s_wb_data_i_1 = 32'd0; s_wb_data_i_2 = 32'd0;
    tick(); tick();
    checkOutput("rst_strobe", {29'd0, s_wb_strobe_o}, 32'd0);
    checkOutput("rst_cyc_busy_owner", {29'd0, s_wb_cyc_o, busy_o, owner_o}, 32'd0);
    checkOutput("rst_comp", comp(), 32'd0);
    checkOutput("rst_addr", s_wb_addr_o, 32'd0);
    checkOutput("rst_m0data", m0_wb_data_o, 32'd0);
    reset = 1'b0;

    // m0 read from rom_0, unselected acks ignored, rom acks later with 0xA5
    applyStimulus(0, 1, 1, 0, 32'h0000_0004, 32'd0);
    tick();
    checkOutput("rd_strobe", {29'd0, s_wb_strobe_o}, 32'h1);
    checkOutput("rd_cyc_busy_owner", {29'd0, s_wb_cyc_o, busy_o, owner_o}, 32'h6);
    checkOutput("rd_addr", s_wb_addr_o, 32'h0000_0004);
    s_wb_ack_i = 3'b110;
    tick();
    checkOutput("rd_ignore_other_ack", {29'd0, s_wb_strobe_o}, 32'h1);
    s_wb_ack_i = 3'b001; s_wb_data_i_0 = 32'h0000_00A5;
    tick();
    checkOutput("rd_comp", comp(), 32'h1);
    checkOutput("rd_strobe_drop", {29'd0, s_wb_strobe_o}, 32'd0);
    checkOutput("rd_data", m0_wb_data_o, 32'h0000_00A5);
    s_wb_ack_i = 3'b000;
    applyStimulus(0, 0, 0, 0, 32'd0, 32'd0);
    tick();
    checkOutput("rd_idle_comp", comp(), 32'd0);
    checkOutput("rd_idle_busy", {31'd0, busy_o}, 32'd0);

    // m1 write 0xDEAD to ram_1
    applyStimulus(1, 1, 1, 1, 32'h0002_0010, 32'h0000_DEAD);
    tick();
    checkOutput("wr_strobe", {29'd0, s_wb_strobe_o}, 32'h4);
    checkOutput("wr_we_owner", {30'd0, s_wb_we_o, owner_o}, 32'h3);
    checkOutput("wr_data", s_wb_data_o, 32'h0000_DEAD);
    s_wb_ack_i = 3'b100; s_wb_data_i_2 = 32'h1234_5678;
    tick();
    checkOutput("wr_comp", comp(), 32'h4);
    checkOutput("wr_m1data_unchanged", m1_wb_data_o, 32'd0);
    s_wb_ack_i = 3'b000;
    applyStimulus(1, 0, 0, 0, 32'd0, 32'd0);
    tick();

    // Both masters request and hold: m0, then m1, then m0
    applyStimulus(0, 1, 1, 0, 32'h0001_0000, 32'd0);
    applyStimulus(1, 1, 1, 0, 32'h0001_0008, 32'd0);
    tick();
    checkOutput("tie1_owner", {31'd0, owner_o}, 32'd0);
    checkOutput("tie1_strobe", {29'd0, s_wb_strobe_o}, 32'h2);
    s_wb_ack_i = 3'b010; s_wb_data_i_1 = 32'h0000_0011;
    tick();
    checkOutput("tie1_comp", comp(), 32'h1);
    s_wb_ack_i = 3'b000;
    tick();
    checkOutput("tie_gap_busy", {31'd0, busy_o}, 32'd0);
    tick();
    checkOutput("tie2_owner", {31'd0, owner_o}, 32'd1);
    checkOutput("tie2_addr", s_wb_addr_o, 32'h0001_0008);
    s_wb_ack_i = 3'b010; s_wb_data_i_1 = 32'h0000_0022;
    tick();
    checkOutput("tie2_comp", comp(), 32'h4);
    checkOutput("tie2_m1data", m1_wb_data_o, 32'h0000_0022);
    checkOutput("tie2_m0data", m0_wb_data_o, 32'h0000_0011);
    s_wb_ack_i = 3'b000;
    tick();
    tick();
    checkOutput("tie3_owner", {31'd0, owner_o}, 32'd0);
    s_wb_ack_i = 3'b010; s_wb_data_i_1 = 32'h0000_0033;
    tick();
    checkOutput("tie3_m0data", m0_wb_data_o, 32'h0000_0033);
    s_wb_ack_i = 3'b000;
    applyStimulus(0, 0, 0, 0, 32'd0, 32'd0);
    applyStimulus(1, 0, 0, 0, 32'd0, 32'd0);
    tick();

    // Unmapped slave: immediate error, no strobe
    applyStimulus(0, 1, 1, 0, 32'h0003_0000, 32'd0);
    tick();
    checkOutput("unm_strobe_cyc", {28'd0, s_wb_cyc_o, s_wb_strobe_o}, 32'd0);
    checkOutput("unm_comp", comp(), 32'h2);
    checkOutput("unm_busy", {31'd0, busy_o}, 32'd1);
    applyStimulus(0, 0, 0, 0, 32'd0, 32'd0);
    tick();
    checkOutput("unm_after_comp", comp(), 32'd0);
    checkOutput("unm_m0data", m0_wb_data_o, 32'h0000_0033);

    // ram_0 never acks: error after exactly 15 ACTIVE cycles
    applyStimulus(0, 1, 1, 0, 32'h0001_0000, 32'd0);
    tick();
    for (int i = 0; i < 14; i++) tick();
    checkOutput("to_still_active", {28'd0, s_wb_cyc_o, s_wb_strobe_o}, 32'hA);
    checkOutput("to_no_comp_yet", comp(), 32'd0);
    tick();
    checkOutput("to_comp", comp(), 32'h2);
    checkOutput("to_cyc_drop", {31'd0, s_wb_cyc_o}, 32'd0);
    applyStimulus(0, 0, 0, 0, 32'd0, 32'd0);
    tick();

    // Reset pulsed while ACTIVE
    applyStimulus(1, 1, 1, 0, 32'h0000_0000, 32'd0);
    tick();
    checkOutput("rst_mid_pre_strobe", {29'd0, s_wb_strobe_o}, 32'h1);
    reset = 1'b1;
    tick();
    checkOutput("rst_mid_strobe_cyc", {28'd0, s_wb_cyc_o, s_wb_strobe_o}, 32'd0);
    checkOutput("rst_mid_comp", comp(), 32'd0);
    checkOutput("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    reset = 1'b0;
    applyStimulus(1, 0, 0, 0, 32'd0, 32'd0);
    tick();
    checkOutput("rst_mid_after_comp", comp(), 32'd0);

    // Owner drops cyc during ACTIVE: abort, then tie goes to m1
    applyStimulus(0, 1, 1, 0, 32'h0002_0000, 32'd0);
    tick();
    checkOutput("ab_strobe", {29'd0, s_wb_strobe_o}, 32'h4);
    applyStimulus(0, 0, 0, 0, 32'h0002_0000, 32'd0);
    tick();
    checkOutput("ab_strobe_cyc", {28'd0, s_wb_cyc_o, s_wb_strobe_o}, 32'd0);
    checkOutput("ab_comp", comp(), 32'd0);
    checkOutput("ab_busy", {31'd0, busy_o}, 32'd0);
    applyStimulus(0, 1, 1, 0, 32'h0000_0000, 32'd0);
    applyStimulus(1, 1, 1, 0, 32'h0000_0000, 32'd0);
    tick();
    checkOutput("ab_next_owner", {31'd0, owner_o}, 32'd1);
    s_wb_ack_i = 3'b001; s_wb_data_i_0 = 32'h0000_0077;
    tick();
    checkOutput("ab_next_comp", comp(), 32'h4);
    checkOutput("ab_next_m1data", m1_wb_data_o, 32'h0000_0077);
    s_wb_ack_i = 3'b000;
    applyStimulus(0, 0, 0, 0, 32'd0, 32'd0);
    applyStimulus(1, 0, 0, 0, 32'd0, 32'd0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wb_backdoor_arbiter.md
WB_BACKDOOR_ARBITER -- requirements
Module: wb_backdoor_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, giving the max ACTIVE cycles without slave ack before error completion (legal range 1..255).
REQ-002 SHALL have port clock  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have, for N = 0,1, port mN_wb_data_i  input  32  master N write data.
REQ-005 SHALL have port mN_wb_addr_i  input  32  master N address; bits [17:16] select the slave.
REQ-006 SHALL have port mN_wb_cyc_i / mN_wb_strobe_i / mN_wb_we_i  input  1 each  master N cycle, strobe, write enable.
REQ-007 SHALL have port mN_wb_data_o  output  32  master N read data.
REQ-008 SHALL have port mN_wb_ack_o / mN_wb_err_o  output  1 each  master N completion / error.
REQ-009 SHALL have port s_wb_data_o / s_wb_addr_o  output  32 each  registered write data / address to all slaves.
REQ-010 SHALL have port s_wb_we_o / s_wb_cyc_o  output  1 each  registered write enable / cycle.
REQ-011 SHALL have port s_wb_strobe_o  output  3  one-hot strobe: bit0 rom_0, bit1 ram_0, bit2 ram_1.
REQ-012 SHALL have port s_wb_data_i_0/1/2  input  32 each  read data from rom_0, ram_0, ram_1.
REQ-013 SHALL have port s_wb_ack_i  input  3  per-slave ack, same bit order as strobe.
REQ-014 SHALL have port busy_o  output  1  high whenever state is not IDLE; port owner_o  output  1  index of the granted master.

Function
REQ-015 SHALL implement FSM states IDLE, ACTIVE, DONE; request N = mN_wb_cyc_i & mN_wb_strobe_i.
REQ-016 In IDLE with exactly one request, SHALL grant that master; with both requesting, SHALL grant the master not granted last (register last, reset 1, so m0 wins first).
REQ-017 On grant at edge E, SHALL register addr/data/we of the winner, set owner_o, enter ACTIVE; s_wb_cyc_o and the strobe are visible the cycle after E (1-cycle request-to-strobe latency).
REQ-018 SHALL decode addr[17:16]: 0 -> bit0, 1 -> bit1, 2 -> bit2; 3 is unmapped: no strobe, go directly to DONE with error.
REQ-019 In ACTIVE, SHALL hold strobe/cyc/addr/data/we stable until the selected slave's ack bit is sampled high; acks from unselected slaves SHALL be ignored.
REQ-020 On a sampled selected ack, SHALL capture that slave's read data (reads only), drop strobe and cyc at the same edge, and enter DONE.
REQ-021 SHALL count ACTIVE cycles; when TIMEOUT cycles elapse without ack, SHALL drop strobe and cyc and enter DONE with error.
REQ-022 In DONE, SHALL assert exactly one of mN_wb_ack_o / mN_wb_err_o for the owner for exactly one cycle, return to IDLE, and keep the other master's ack/err low.
REQ-023 mN_wb_data_o SHALL hold the last captured read data for master N; writes and errors SHALL leave it unchanged.
REQ-024 If the owner deasserts cyc during ACTIVE, SHALL abort: drop strobe/cyc at the next edge, return to IDLE, no ack/err, last updated as if completed.
REQ-025 A request still high in the IDLE cycle after DONE SHALL be treated as a new transaction (minimum 3 cycles plus slave latency per transfer).

Reset
REQ-026 On reset, SHALL set state IDLE, last=1, timer=0, all strobes/cyc/we/ack/err/busy_o/owner_o to 0 and all data/addr outputs to 0.
REQ-027 Reset asserted mid-transaction SHALL drop strobe/cyc at that edge with no ack/err issued.

Verification
REQ-028 m0 reads addr 0x0000_0004, rom acks 2 cycles after strobe with 0xA5 -> s_wb_strobe_o=3'b001, m0_wb_ack_o for one cycle, m0_wb_data_o=0xA5.
REQ-029 m0 and m1 request in the same cycle, both held -> m0 served first, then m1; the third grant goes to m0 again.
REQ-030 m1 writes 0xDEAD to addr 0x0002_0010 -> s_wb_strobe_o=3'b100, we=1, m1 ack, m1_wb_data_o unchanged.
REQ-031 Access to addr 0x0003_0000 -> no strobe, m0_wb_err_o for one cycle; access to ram_0 with no ack -> err after exactly 15 ACTIVE cycles.
REQ-032 Reset pulsed during ACTIVE, and a separate cyc drop by the owner -> strobe low at the next edge, no ack/err, busy_o=0.
